// File: rtl/blackbox_ctrl_pkg.sv
// Shared types and constants for the blackbox sweep/query controller.
// Bit-order convention: a vector index is {n,j,s}, with n as the MSB.
package blackbox_ctrl_pkg;

    localparam int VEC_W   = 3;
    localparam int TABLE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SW_SETTLE = 3'd1,
        SW_CAP    = 3'd2,
        SW_FIN    = 3'd3,
        Q_SETTLE  = 3'd4,
        Q_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/blackbox_sweeper_settle_timer.sv
// 4-bit load/count-down timer with zero flag, shared by the sweep and query paths.
module settle_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    // Load takes precedence; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/blackbox_sweeper.sv
// Sequencing controller for a 3-in/1-out combinational blackbox: full
// truth-table sweep against an expected table, plus single-vector queries.
module blackbox_sweeper
    import blackbox_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [TABLE_W-1:0] expected,
    input  logic               q_valid,
    input  logic [VEC_W-1:0]   q_vec,
    output logic               q_ready,
    output logic               r_valid,
    output logic               r_h,
    output logic               bb_n,
    output logic               bb_j,
    output logic               bb_s,
    input  logic               bb_h,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic               pass,
    output logic [VEC_W-1:0]   mismatch_idx
);

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t             state, state_nxt;
    logic [VEC_W-1:0]   idx;
    logic [VEC_W-1:0]   vec;
    logic [TABLE_W-1:0] exp_q;
    logic [TABLE_W-1:0] table_nxt;
    logic [TABLE_W-1:0] diff;
    logic [VEC_W-1:0]   mis_nxt;
    logic               tmr_load, tmr_dec, tmr_zero;

    settle_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (SETTLE_M1),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic, timer control and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SW_SETTLE;
                    tmr_load  = 1'b1;
                end else if (q_valid) begin
                    state_nxt = Q_SETTLE;
                    tmr_load  = 1'b1;
                end
            end
            SW_SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_nxt = SW_CAP;
            end
            SW_CAP: begin
                if (idx == 3'd7) begin
                    state_nxt = SW_FIN;
                end else begin
                    state_nxt = SW_SETTLE;
                    tmr_load  = 1'b1;
                end
            end
            SW_FIN:   state_nxt = IDLE;
            Q_SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_nxt = Q_RESP;
            end
            Q_RESP:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == SW_FIN);
    assign r_valid = (state == Q_RESP);
    // Gated by reset so every output reads 0 while reset is asserted.
    assign q_ready = reset_n && (state == IDLE) && !start;
    assign {bb_n, bb_j, bb_s} = vec;

    // Table including the bit captured this cycle, so the compare can be
    // registered on the same edge that enters SW_FIN.
    always_comb begin
        table_nxt      = table_out;
        table_nxt[idx] = bb_h;
        diff           = table_nxt ^ exp_q;
        mis_nxt        = '0;
        for (int i = TABLE_W - 1; i >= 0; i--)
            if (diff[i]) mis_nxt = VEC_W'(i);
    end

    // Datapath: vector drive, capture, results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx          <= '0;
            vec          <= '0;
            exp_q        <= '0;
            table_out    <= '0;
            pass         <= 1'b0;
            mismatch_idx <= '0;
            r_h          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        vec          <= '0;
                        exp_q        <= expected;
                        table_out    <= '0;
                        pass         <= 1'b0;
                        mismatch_idx <= '0;
                    end else if (q_valid) begin
                        vec <= q_vec;
                    end
                end
                SW_CAP: begin
                    table_out <= table_nxt;
                    if (idx == 3'd7) begin
                        vec          <= '0;
                        pass         <= (diff == '0);
                        mismatch_idx <= mis_nxt;
                    end else begin
                        idx <= idx + 3'd1;
                        vec <= idx + 3'd1;
                    end
                end
                Q_SETTLE: begin
                    if (tmr_zero) begin
                        r_h <= bb_h;
                        vec <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Directed bench: sweep pass/fail, queries, start/query collision,
// reset mid-sweep, and a SETTLE=3 instance with a glitching blackbox.
module tb_blackbox_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, q_valid, start2, glitch;
    logic [7:0] expected, expected2;
    logic [2:0] q_vec;
    logic       q_valid2 = 1'b0;
    logic [2:0] q_vec2 = 3'd0;

    logic       q_ready, r_valid, r_h, bb_n, bb_j, bb_s, bb_h, busy, done, pass;
    logic [7:0] table_out;
    logic [2:0] mismatch_idx;

    logic       q_ready2, r_valid2, r_h2, bb_n2, bb_j2, bb_s2, bb_h2, busy2, done2, pass2;
    logic [7:0] table_out2;
    logic [2:0] mismatch_idx2;

    // Blackbox model: h = n & (j | s); second copy adds a settle-time glitch.
    assign bb_h  = bb_n & (bb_j | bb_s);
    assign bb_h2 = (bb_n2 & (bb_j2 | bb_s2)) ^ glitch;

    blackbox_sweeper #(.SETTLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .expected(expected),
        .q_valid(q_valid), .q_vec(q_vec), .q_ready(q_ready), .r_valid(r_valid),
        .r_h(r_h), .bb_n(bb_n), .bb_j(bb_j), .bb_s(bb_s), .bb_h(bb_h),
        .busy(busy), .done(done), .table_out(table_out), .pass(pass),
        .mismatch_idx(mismatch_idx)
    );

    blackbox_sweeper #(.SETTLE(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start2), .expected(expected2),
        .q_valid(q_valid2), .q_vec(q_vec2), .q_ready(q_ready2), .r_valid(r_valid2),
        .r_h(r_h2), .bb_n(bb_n2), .bb_j(bb_j2), .bb_s(bb_s2), .bb_h(bb_h2),
        .busy(busy2), .done(done2), .table_out(table_out2), .pass(pass2),
        .mismatch_idx(mismatch_idx2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the SETTLE=1 instance; returns cycles since acceptance.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc, bad, ndone;
        reset_n = 1'b0; start = 1'b0; q_valid = 1'b0; q_vec = 3'd0;
        expected = 8'h00; start2 = 1'b0; expected2 = 8'h00; glitch = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_q_ready", q_ready, 0);
        chk("rst_table", table_out, 0);
        chk("rst_bb", {bb_n, bb_j, bb_s}, 0);
        chk("rst_done_rvalid", {done, r_valid, r_h, pass}, 0);
        reset_n = 1'b1;
        step();

        // Sweep, pass case.
        expected = 8'hE0; start = 1'b1; #1;
        chk("start_blocks_q_ready", q_ready, 0);
        step(); start = 1'b0;
        chk("sw1_busy", busy, 1);
        wait_done(cyc);
        chk("sw1_latency", cyc, 17);
        chk("sw1_table", table_out, 8'hE0);
        chk("sw1_pass", pass, 1);
        chk("sw1_mis", mismatch_idx, 0);
        step();
        chk("sw1_idle", {busy, done, bb_n, bb_j, bb_s}, 0);

        // Sweep, fail case; acceptance clears previous results.
        expected = 8'hE8; start = 1'b1;
        step(); start = 1'b0;
        chk("sw2_clr_table", table_out, 0);
        chk("sw2_clr_pass", pass, 0);
        wait_done(cyc);
        chk("sw2_latency", cyc, 17);
        chk("sw2_table", table_out, 8'hE0);
        chk("sw2_pass", pass, 0);
        chk("sw2_mis", mismatch_idx, 3);
        step();

        // Query 101 -> h=1.
        q_vec = 3'b101; q_valid = 1'b1; #1;
        chk("q1_ready", q_ready, 1);
        step(); q_valid = 1'b0;
        chk("q1_bb", {bb_n, bb_j, bb_s}, 3'b101);
        chk("q1_rvalid_early", r_valid, 0);
        step();
        chk("q1_rvalid", r_valid, 1);
        chk("q1_rh", r_h, 1);
        step();
        chk("q1_after", {r_valid, r_h, bb_n, bb_j, bb_s}, 5'b01000);

        // Query 100 -> h=0.
        q_vec = 3'b100; q_valid = 1'b1;
        step(); q_valid = 1'b0;
        step();
        chk("q2_rvalid", r_valid, 1);
        chk("q2_rh", r_h, 0);
        step();

        // Collision: sweep wins, query waits and is served after done.
        expected = 8'hE0; q_vec = 3'b111; start = 1'b1; q_valid = 1'b1;
        step(); start = 1'b0;
        chk("coll_sweep", busy, 1);
        cyc = 1; bad = 0;
        while (!done && cyc < 60) begin
            if (q_ready || r_valid) bad++;
            step();
            cyc++;
        end
        if (q_ready) bad++;
        chk("coll_no_q_ready", bad, 0);
        chk("coll_latency", cyc, 17);
        step();
        chk("coll_q_ready_idle", q_ready, 1);
        step(); q_valid = 1'b0;
        chk("coll_q_bb", {bb_n, bb_j, bb_s}, 3'b111);
        step();
        chk("coll_rvalid", r_valid, 1);
        chk("coll_rh", r_h, 1);
        step();

        // Reset mid-sweep at idx=4.
        expected = 8'hE0; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("rst_mid_bb_idx4", {bb_n, bb_j, bb_s}, 3'b100);
        reset_n = 1'b0;
        step(); reset_n = 1'b1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_table", table_out, 0);
        chk("rst_mid_bb", {bb_n, bb_j, bb_s}, 0);
        chk("rst_mid_rh", r_h, 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) ndone++;
            step();
        end
        chk("rst_mid_no_done", ndone, 0);
        expected = 8'hE8; start = 1'b1;
        step(); start = 1'b0;
        wait_done(cyc);
        chk("rst_fresh_latency", cyc, 17);
        chk("rst_fresh_table", table_out, 8'hE0);
        chk("rst_fresh_mis", mismatch_idx, 3);
        step();

        // SETTLE=3: glitch bb_h in the first settle cycle of each vector.
        expected2 = 8'hE0; start2 = 1'b1;
        step(); start2 = 1'b0;
        cyc = 1; glitch = 1'b1;
        while (!done2 && cyc < 100) begin
            step();
            cyc++;
            glitch = (cyc % 4 == 1);
        end
        glitch = 1'b0;
        chk("s3_latency", cyc, 33);
        chk("s3_table", table_out2, 8'hE0);
        chk("s3_pass", pass2, 1);
        step();
        chk("s3_idle", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/blackbox_sweeper.md
Name: blackbox_sweeper

Overview:
- Sequencing controller for a 3-input/1-output combinational blackbox (inputs n, j, s; output h).
- Owns the blackbox input pins. Serves two requesters: a full truth-table sweep (start/done handshake) and single-vector queries (valid/ready).
- The sweep compares the captured 8-entry table against an expected table and reports pass/fail plus the first mismatching index.

Parameters:
SETTLE, 1, cycles a vector is held on bb_n/bb_j/bb_s before bb_h is sampled; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  sweep request; sampled only in IDLE
expected  input  8  expected truth table, indexed {n,j,s}; latched when start is accepted
q_valid  input  1  query request
q_vec  input  3  query vector {n,j,s}
q_ready  output  1  high only in IDLE when start is low; query accepted on q_valid & q_ready
r_valid  output  1  one-cycle pulse carrying a query result
r_h  output  1  sampled bb_h for the last query; held until the next query
bb_n  output  1  registered drive to blackbox input n
bb_j  output  1  registered drive to blackbox input j
bb_s  output  1  registered drive to blackbox input s
bb_h  input  1  blackbox output
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a sweep completes
table_out  output  8  captured truth table; bit idx = h for {n,j,s}=idx
pass  output  1  table_out == latched expected; valid from done, held until next accepted start
mismatch_idx  output  3  lowest idx where table_out != expected; 0 when pass

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low (reset_n).
- Reset values: all outputs 0, state IDLE. Reset also clears the latched expected value and the internal index and settle counter.
- Reset mid-operation: sampled reset_n=0 aborts any sweep or query at that edge. No done or r_valid is produced.
- States:
  - IDLE.
  - SW_SETTLE: SETTLE cycles.
  - SW_CAP: 1 cycle.
  - SW_FIN: 1 cycle.
  - Q_SETTLE: SETTLE cycles.
  - Q_RESP: 1 cycle.
- Arbitration in IDLE: start has priority over q_valid. If both are high, the sweep is accepted, q_ready stays 0 and the query waits. Outside IDLE, start is ignored and q_ready=0.
- Sweep acceptance (IDLE & start):
  - idx<=0; {bb_n,bb_j,bb_s}<=3'b000; expected latched.
  - table_out, pass and mismatch_idx cleared to 0.
  - Next state SW_SETTLE.
- SW_SETTLE: hold the vector for SETTLE cycles (counter loaded SETTLE-1, counts to 0), then go to SW_CAP.
- SW_CAP:
  - At the end of the cycle, table_out[idx]<=bb_h.
  - If idx==7, go to SW_FIN.
  - Otherwise idx<=idx+1, drive {bb_n,bb_j,bb_s}<=idx+1, go to SW_SETTLE.
  - idx is 3 bits; it never wraps because the idx==7 check precedes the increment.
- SW_FIN:
  - done=1 for this cycle only.
  - pass and mismatch_idx are computed combinationally from table_out and expected and registered at entry, so they are valid in the same cycle as done.
  - The bb_* pins return to 0. Next state IDLE.
- Sweep latency: accepted at edge E; done is high in cycle 8*(SETTLE+1)+1 after E (17 for SETTLE=1). busy is high from E until the edge ending SW_FIN.
- Query (IDLE & q_valid & ~start):
  - {bb_n,bb_j,bb_s}<=q_vec. Hold in Q_SETTLE for SETTLE cycles.
  - Q_RESP: r_valid=1 for one cycle; r_h<=bb_h is registered at entry so r_h is valid with r_valid.
  - Then IDLE, with bb_* at 0.
  - Query latency: r_valid is high in cycle SETTLE+1 after acceptance.
- Sweep results persist across queries. Query results persist across sweeps.
- Back-to-back operation: start or q_valid may be accepted in the first IDLE cycle after SW_FIN or Q_RESP. Minimum gap is one IDLE cycle.

Decomposition:
- Shared package blackbox_ctrl_pkg holds:
  - the state enum (IDLE, SW_SETTLE, SW_CAP, SW_FIN, Q_SETTLE, Q_RESP);
  - VEC_W=3 and TABLE_W=8;
  - the bit-order convention: idx = {n,j,s}, n is the MSB.
- One sub-module: settle_timer (load, count-down, zero flag, 4-bit). It is shared by the sweep and query paths.
- The mismatch priority encoder stays inline.

Test Plan:
- Sweep, pass case: bench models bb_h = n & (j | s); start with expected=8'hE0, SETTLE=1 -> done high exactly 17 cycles after acceptance; table_out=8'hE0, pass=1, mismatch_idx=0.
- Sweep, fail case: same model, expected=8'hE8 -> pass=0, mismatch_idx=3, table_out=8'hE0. A second start clears pass and table_out at acceptance.
- Query: q_valid with q_vec=3'b101 in IDLE -> bb pins show 1,0,1 for SETTLE cycles; r_valid pulses in cycle 2 with r_h=1. q_vec=3'b100 -> r_h=0.
- Collision: start and q_valid high together in IDLE -> sweep runs and q_ready=0 throughout busy. The held query is accepted in the first IDLE cycle after done and returns the correct r_h.
- Reset mid-sweep: reset_n=0 for one cycle at idx=4 -> next cycle busy=0, table_out=0, bb pins 0, no done pulse. A fresh sweep then completes normally.
- SETTLE=3 build: sweep completes in 33 cycles. During each vector, bench toggles bb_h only in the first settle cycle, and the value captured is the one held at SW_CAP.
